nios_mult_cell_pipe: RTL and testbench

Parametrised, pipelined integer multiplier cell for the Nios II custom datapath. It is the successor to the fixed 32x32, low-word-only, two-slice multiplier cell. Adds:
- configurable operand width and slice width
- selectable signed/unsigned high-word modes (mul, mulxss, mulxsu, mulxuu)
- valid/ready handshake with back-pressure

It sits between the A-stage operand registers and the writeback mux.

---
 rtl/nios_mult_cell_pipe.sv | 197 +++++++++++++++++++
 tb/tb_nios_mult_cell_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_mult_cell_pipe.sv
// Pipelined DATA_W x DATA_W multiplier cell with mul/mulxss/mulxsu/mulxuu modes and a valid/ready handshake.
// Optional overflow flag for mode 00 is enabled by defining NIOS_MULT_CELL_OVF_EN.
module nios_mult_cell_pipe #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
`ifdef NIOS_MULT_CELL_OVF_EN
    output logic              ovf,
`endif
    output logic              busy
);

    localparam int NS = DATA_W / SLICE_W;
    localparam int RW = DATA_W + SLICE_W;
    localparam int PW = 2 * DATA_W;

`ifdef NIOS_MULT_CELL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef logic [NS-1:0][NS-1:0][2*SLICE_W-1:0] pp_t;
    typedef logic [NS-1:0][RW-1:0]                row_t;

    // One row per src1 slice: the src2 slices' partial products aligned and summed.
    function automatic row_t rows_of(input pp_t pp);
        row_t r;
        for (int i = 0; i < NS; i++) begin
            r[i] = '0;
            for (int j = 0; j < NS; j++)
                r[i] = r[i] + (RW'(pp[i][j]) << (j * SLICE_W));
        end
        return r;
    endfunction

    // Unsigned product minus the sign corrections gives the signed product mod 2^PW.
    function automatic logic [PW-1:0] sum_rows(input row_t r, input logic [DATA_W-1:0] corr);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NS; i++)
            acc = acc + (PW'(r[i]) << (i * SLICE_W));
        acc = acc - {corr, {DATA_W{1'b0}}};
        return acc;
    endfunction

    logic                en;
    logic [LATENCY-1:0]  v_d, v_q;
    logic                a_sgn, b_sgn;
    pp_t                 pp1_d;
    logic [DATA_W-1:0]   corr1_d;
    logic                lo1_d;
    logic [PW-1:0]       prod_f;
    logic                lo_f;
    logic [DATA_W-1:0]   result_d, result_q;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[LATENCY-1];
    assign busy      = |v_q;
    assign result    = result_q;

    // With the overflow flag enabled, mode 00 is formed signed so the high word is meaningful;
    // the low word is the same either way.
    always_comb begin
        a_sgn   = src1[DATA_W-1] & ((mode == 2'b01) | (mode == 2'b10) | (OVF_EN & (mode == 2'b00)));
        b_sgn   = src2[DATA_W-1] & ((mode == 2'b01) | (OVF_EN & (mode == 2'b00)));
        lo1_d   = (mode == 2'b00);
        corr1_d = (a_sgn ? src2 : '0) + (b_sgn ? src1 : '0);
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++)
                pp1_d[i][j] = {{SLICE_W{1'b0}}, src1[i*SLICE_W +: SLICE_W]}
                            * {{SLICE_W{1'b0}}, src2[j*SLICE_W +: SLICE_W]};
    end

    always_comb begin
        v_d[0] = in_valid;
        for (int k = 1; k < LATENCY; k++)
            v_d[k] = v_q[k-1];
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            always_comb begin
                prod_f = sum_rows(rows_of(pp1_d), corr1_d);
                lo_f   = lo1_d;
            end
        end else begin : g_latn
            pp_t               pp1_q;
            logic [DATA_W-1:0] corr1_q;
            logic              lo1_q;

            // NOTE: datapath registers carry no reset; only the valid bits and the output
            // register are reset, since data behind a zero valid bit is never observed.
            always_ff @(posedge clk) begin
                if (en) begin
                    pp1_q   <= pp1_d;
                    corr1_q <= corr1_d;
                    lo1_q   <= lo1_d;
                end
            end

            if (LATENCY == 2) begin : g_lat2
                always_comb begin
                    prod_f = sum_rows(rows_of(pp1_q), corr1_q);
                    lo_f   = lo1_q;
                end
            end else begin : g_lat34
                row_t              rows2_d, rows2_q;
                logic [DATA_W-1:0] corr2_d, corr2_q;
                logic              lo2_d, lo2_q;

                always_comb begin
                    rows2_d = rows_of(pp1_q);
                    corr2_d = corr1_q;
                    lo2_d   = lo1_q;
                end

                always_ff @(posedge clk) begin
                    if (en) begin
                        rows2_q <= rows2_d;
                        corr2_q <= corr2_d;
                        lo2_q   <= lo2_d;
                    end
                end

                if (LATENCY == 3) begin : g_lat3
                    always_comb begin
                        prod_f = sum_rows(rows2_q, corr2_q);
                        lo_f   = lo2_q;
                    end
                end else begin : g_lat4
                    logic [PW-1:0] prod3_d, prod3_q;
                    logic          lo3_d, lo3_q;

                    always_comb begin
                        prod3_d = sum_rows(rows2_q, corr2_q);
                        lo3_d   = lo2_q;
                    end

                    always_ff @(posedge clk) begin
                        if (en) begin
                            prod3_q <= prod3_d;
                            lo3_q   <= lo3_d;
                        end
                    end

                    always_comb begin
                        prod_f = prod3_q;
                        lo_f   = lo3_q;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        result_d = lo_f ? prod_f[DATA_W-1:0] : prod_f[PW-1:DATA_W];
    end

`ifdef NIOS_MULT_CELL_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = lo_f & (prod_f[PW-1:DATA_W] != {DATA_W{prod_f[DATA_W-1]}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  ovf_q <= 1'b0;
        else if (en)   ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q      <= '0;
            result_q <= '0;
        end else if (en) begin
            v_q      <= v_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_nios_mult_cell_pipe.sv
// Directed-vector bench for nios_mult_cell_pipe: modes, latency, back-pressure, mid-flight reset, optional ovf.
module tb_nios_mult_cell_pipe;

    localparam int DW  = 32;
    localparam int SW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] src1 = '0;
    logic [DW-1:0] src2 = '0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] result;
    logic          busy;
    logic          ovf_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nios_mult_cell_pipe #(.DATA_W(DW), .SLICE_W(SW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef NIOS_MULT_CELL_OVF_EN
        .ovf       (ovf_o),
`endif
        .busy      (busy)
    );

`ifndef NIOS_MULT_CELL_OVF_EN
    assign ovf_o = 1'b0;
`endif

    typedef struct {
        logic [1:0]    m;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
        logic          eovf;
    } vec_t;

    // Issues one op from idle with out_ready high and reports what came out and when.
    task automatic run_op(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] res, output int lat, output logic ov, output logic after);
        @(negedge clk);
        mode = m; src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b1;
        lat = -1; res = '0; ov = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = k; res = result; ov = ovf_o;
                break;
            end
        end
        @(negedge clk);
        after = out_valid;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got %b want 0", out_valid); end
    endtask

    task automatic test_mul_low();
        logic [DW-1:0] res; int lat; logic ov, after;
        run_op(2'b00, 32'h0001_0003, 32'h0000_0005, res, lat, ov, after);
        vectors++; if (res !== 32'h0005_000F) begin miscompares++; $display("FAIL mul_low_result got %h want 0005000f", res); end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL mul_low_latency got %0d want %0d", lat, LAT); end
        vectors++; if (after !== 1'b0) begin miscompares++; $display("FAIL mul_low_pulse got %b want 0", after); end
    endtask

    task automatic test_modes();
        vec_t tbl [11];
        logic [DW-1:0] res; int lat; logic ov, after;
        tbl[0]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        tbl[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        tbl[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[5]  = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        tbl[6]  = '{2'b01, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[7]  = '{2'b11, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 1'b0};
        tbl[8]  = '{2'b10, 32'h8000_0000, 32'h0000_0004, 32'hFFFF_FFFE, 1'b0};
        tbl[9]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        tbl[10] = '{2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 32'h3FFF_FFFF, 1'b0};
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].m, tbl[i].a, tbl[i].b, res, lat, ov, after);
            vectors++;
            if (res !== tbl[i].exp || lat !== LAT) begin
                miscompares++;
                $display("FAIL mode_vec%0d got %h lat %0d want %h lat %0d", i, res, lat, tbl[i].exp, LAT);
            end
`ifdef NIOS_MULT_CELL_OVF_EN
            vectors++; if (ov !== tbl[i].eovf) begin miscompares++; $display("FAIL mode_vec%0d_ovf got %b want %b", i, ov, tbl[i].eovf); end
`endif
        end
    endtask

    task automatic test_mode_switch();
        logic [DW-1:0] got [4];
        int n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (k < 2);
            mode      = (k == 0) ? 2'b11 : 2'b00;
            src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
            #1;
            if (out_valid && n < 4) begin got[n] = result; n++; end
        end
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL switch_count got %0d want 2", n); end
        vectors++; if (got[0] !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL switch_first got %h want fffffffe", got[0]); end
        vectors++; if (got[1] !== 32'h0000_0001) begin miscompares++; $display("FAIL switch_second got %h want 00000001", got[1]); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q [8];
        int snd = 0;
        int rcv = 0;
        for (int i = 0; i < 8; i++) exp_q[i] = 32'(i * 3 * (i + 1));
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            mode      = 2'b00;
            in_valid  = (snd < 8);
            src1      = 32'(snd * 3);
            src2      = 32'(snd + 1);
            #1;
            if (out_valid && !out_ready) begin
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_in_ready cycle %0d got %b want 0", c, in_ready); end
                vectors++; if (result !== exp_q[rcv]) begin miscompares++; $display("FAIL b2b_held cycle %0d got %h want %h", c, result, exp_q[rcv]); end
            end
            if (out_valid && out_ready) begin
                vectors++; if (result !== exp_q[rcv]) begin miscompares++; $display("FAIL b2b_result%0d got %h want %h", rcv, result, exp_q[rcv]); end
                rcv++;
            end
            if (in_valid && in_ready) snd++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        vectors++; if (rcv !== 8) begin miscompares++; $display("FAIL b2b_count got %0d want 8", rcv); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_extra_output got %b want 0", out_valid); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] res; int lat; logic ov, after;
        @(negedge clk);
        mode = 2'b00; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        src1 = 32'd5; src2 = 32'd6;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midflight_busy_before got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midflight_out_valid got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midflight_busy got %b want 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'b00, 32'd7, 32'd6, res, lat, ov, after);
        vectors++; if (res !== 32'd42) begin miscompares++; $display("FAIL post_reset_result got %0d want 42", res); end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); end
    endtask

`ifdef NIOS_MULT_CELL_OVF_EN
    task automatic test_ovf();
        logic [DW-1:0] res; int lat; logic ov, after;
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, res, lat, ov, after);
        vectors++; if (res !== 32'h0 || ov !== 1'b1) begin miscompares++; $display("FAIL ovf_big got %h/%b want 0/1", res, ov); end
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, res, lat, ov, after);
        vectors++; if (res !== 32'hFFFF_FFFE || ov !== 1'b0) begin miscompares++; $display("FAIL ovf_neg got %h/%b want fffffffe/0", res, ov); end
        run_op(2'b11, 32'h0001_0000, 32'h0001_0000, res, lat, ov, after);
        vectors++; if (res !== 32'h1 || ov !== 1'b0) begin miscompares++; $display("FAIL ovf_hi_mode got %h/%b want 1/0", res, ov); end
    endtask
`endif

    initial begin
        test_reset();
        test_mul_low();
        test_modes();
        test_mode_switch();
        test_back_to_back();
        test_reset_midflight();
`ifdef NIOS_MULT_CELL_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
